dmem_responder: RTL and testbench
=================================

# dmem_responder

Synthesizable data-memory responder for the RV32I core's data port: it is the memory end of the `d_mem_*` interface that `cpu_top` drives as initiator. It holds word-addressed RAM with byte-lane writes and clears the RAM after reset. It also captures full-word stores into two result windows (DFT results at 0x400, frequency energy at 0x500) into a FIFO that a host or checker drains through a valid/ready handshake.

## Interface
- `MEM_SIZE_WORDS`, 1024: RAM depth in 32-bit words. Power of two.
- `FIFO_DEPTH`, 16: capture FIFO entries. Power of two.
- `WIN0_BASE` / `WIN0_LIMIT`, 32'h400 / 32'h430: capture window 0, `[base, limit)`.
- `WIN1_BASE` / `WIN1_LIMIT`, 32'h500 / 32'h530: capture window 1, `[base, limit)`.

Ports:
- `clk`  in  1  single clock; everything updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `d_mem_addr`  in  32  byte address from the CPU.
- `d_mem_wdata`  in  32  store data.
- `d_mem_wen`  in  4  byte-lane write enables; bit n enables `wdata[8n+7:8n]`.
- `d_mem_rdata`  out  32  combinational read data.
- `init_done`  out  1  high when the RAM clear has finished; used to hold the CPU in reset.
- `cap_valid`  out  1  FIFO head is valid.
- `cap_ready`  in  1  consumer accepts the head.
- `cap_win`  out  1  window of the head entry (0 or 1).
- `cap_addr`  out  32  byte address of the head entry.
- `cap_data`  out  32  store data of the head entry.
- `cap_overflow`  out  1  sticky flag: at least one capture was dropped.
- `drop_count`  out  16  dropped captures; saturates at 16'hFFFF.
- `wr_count`  out  32  accepted RAM writes; wraps.
- `addr_err`  out  1  sticky flag: a write was attempted at `addr >= 4*MEM_SIZE_WORDS`.

## Operation
- FSM states:
  - CLEAR: entered on `rst`. A pointer writes 0 to word 0 through word `MEM_SIZE_WORDS-1`, one word per cycle. After the last word the FSM moves to RUN.
  - RUN: normal operation. The FSM stays in RUN until `rst`.
- In CLEAR:
  - `d_mem_rdata` = 0.
  - CPU writes are ignored; they do not count, do not capture, and do not set flags.
- Read in RUN:
  - `d_mem_rdata = mem[addr[log2(MEM_SIZE_WORDS)+1:2]]` when `addr < 4*MEM_SIZE_WORDS`, otherwise 0. Never X.
  - `addr[1:0]` is ignored.
- Write in RUN:
  - Condition: `wen != 0` and address in range.
  - Each enabled lane updates at the edge.
  - `wr_count` increments by 1.
- Out-of-range write (`wen != 0`): no RAM change, no count; `addr_err` is set to 1.
- Capture:
  - Trigger: in RUN, `wen == 4'b1111` and address inside WIN0 or WIN1.
  - The push is `{win, addr, wdata}`.
  - Partial-lane writes inside a window update RAM but are not captured.
- FIFO behaviour:
  - Show-ahead: `cap_*` reflect the head whenever `cap_valid` is high.
  - A pop happens when `cap_valid && cap_ready`.
  - Push while full without a pop: the entry is dropped, `cap_overflow` is set to 1, and `drop_count` increments (saturating).
  - Push and pop in the same cycle while full: both occur and nothing is dropped.
  - Push and pop in the same cycle while empty: the push lands, `cap_valid` rises next cycle.
- Reset behaviour:
  - `rst` asserted at any time (mid-clear, mid-run, or with the FIFO non-empty) returns the FSM to CLEAR with the pointer at 0.
  - The FIFO is flushed; all counters and flags clear.
  - RAM is not reset directly; it is zeroed by CLEAR.

## Timing
- Reset values:
  - `init_done`, `cap_valid`, `cap_win`, `cap_overflow`, `addr_err` = 0.
  - `cap_addr`, `cap_data`, `drop_count`, `wr_count` = 0.
  - `d_mem_rdata` = 0.
- Clear latency: `init_done` rises exactly `MEM_SIZE_WORDS` cycles after the first edge with `rst` low.
- Read latency: 0 cycles (combinational from address).
- Read-during-write to the same word returns the old data; the new data is visible the cycle after the edge.
- Capture latency: a store at edge N gives `cap_valid` = 1 after edge N, if the FIFO was empty.
- Flag and count latency: `wr_count`, `addr_err`, `cap_overflow`, `drop_count` update at the same edge as the triggering write.

## Test plan
- Reset release: `rst` high for 5 cycles, then low. `init_done` rises after exactly 1024 cycles, and a read of 0x10 returns 0.
- Byte lanes:
  - Write 0x11223344 to 0x20 with `wen=1111`, then 0xAABBCCDD with `wen=0010`.
  - Read of 0x20 returns 0x1122CC44; `wr_count` = 2.
- Capture order:
  - With `cap_ready=0`: store 5 to 0x404, 0xFFFFFFFE to 0x510, and `wen=0011` to 0x408.
  - Head is {0, 0x404, 5}. After one pop the head is {1, 0x510, 0xFFFFFFFE}. After a second pop `cap_valid` = 0; 0x408 was never captured.
- Overflow: with `cap_ready=0`, 17 full stores to 0x400.
  - Result: 16 entries, `cap_overflow` = 1, `drop_count` = 1.
  - Then a store with `cap_ready=1` while full: no additional drop.
- Out of range: write to 0x1000 with `wen=1111`. `addr_err` = 1, `wr_count` unchanged, a read of 0x1000 returns 0.
- Mid-operation reset:
  - `rst` asserted at clear word 500, and separately during RUN with 3 FIFO entries.
  - FIFO is empty and flags clear in both cases. A word written before the reset reads 0 afterwards, and `init_done` is delayed by the full 1024 cycles.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Data-port bundle between the CPU/host side and dmem_responder: memory access
// plus the capture FIFO drain handshake.
interface dmem_responder_if;
    logic [31:0] d_mem_addr;
    logic [31:0] d_mem_wdata;
    logic [3:0]  d_mem_wen;
    logic [31:0] d_mem_rdata;
    logic        init_done;
    logic        cap_valid;
    logic        cap_ready;
    logic        cap_win;
    logic [31:0] cap_addr;
    logic [31:0] cap_data;
    logic        cap_overflow;
    logic [15:0] drop_count;
    logic [31:0] wr_count;
    logic        addr_err;

    modport master (
        output d_mem_addr, d_mem_wdata, d_mem_wen, cap_ready,
        input  d_mem_rdata, init_done, cap_valid, cap_win, cap_addr, cap_data,
        input  cap_overflow, drop_count, wr_count, addr_err
    );

    modport slave (
        input  d_mem_addr, d_mem_wdata, d_mem_wen, cap_ready,
        output d_mem_rdata, init_done, cap_valid, cap_win, cap_addr, cap_data,
        output cap_overflow, drop_count, wr_count, addr_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data RAM with byte-lane writes, post-reset clear sweep and a
// show-ahead FIFO capturing full-word stores into two result windows.
module dmem_responder #(
    parameter int unsigned MEM_SIZE_WORDS = 1024,
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter logic [31:0] WIN0_BASE      = 32'h400,
    parameter logic [31:0] WIN0_LIMIT     = 32'h430,
    parameter logic [31:0] WIN1_BASE      = 32'h500,
    parameter logic [31:0] WIN1_LIMIT     = 32'h530
) (
    input logic         clk,
    input logic         rst,
    dmem_responder_if.slave bus
);
    localparam int unsigned AW        = $clog2(MEM_SIZE_WORDS);
    localparam int unsigned FW        = $clog2(FIFO_DEPTH);
    localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_SIZE_WORDS);

    typedef enum logic {ST_CLEAR, ST_RUN} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] clr_ptr_q, clr_ptr_d;

    logic [31:0]   mem_q [MEM_SIZE_WORDS];

    logic          fifo_win_q  [FIFO_DEPTH];
    logic [31:0]   fifo_addr_q [FIFO_DEPTH];
    logic [31:0]   fifo_data_q [FIFO_DEPTH];
    logic [FW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [FW:0]   cnt_q, cnt_d;

    logic [31:0]   wr_count_q, wr_count_d;
    logic [15:0]   drop_count_q, drop_count_d;
    logic          overflow_q, overflow_d;
    logic          addr_err_q, addr_err_d;

    logic          run, in_range, wr_ok, wr_bad, in_win0, in_win1;
    logic          push_req, pop, full, valid, push_ok, drop;
    logic [AW-1:0] word_idx;

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (state_q == ST_CLEAR) begin
            clr_ptr_d = clr_ptr_q + AW'(1);
            if (clr_ptr_q == AW'(MEM_SIZE_WORDS - 1)) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    assign run      = (state_q == ST_RUN);
    assign in_range = (bus.d_mem_addr < MEM_BYTES);
    assign word_idx = bus.d_mem_addr[AW+1:2];
    assign wr_ok    = run && (bus.d_mem_wen != '0) && in_range;
    assign wr_bad   = run && (bus.d_mem_wen != '0) && !in_range;
    assign in_win0  = (bus.d_mem_addr >= WIN0_BASE) && (bus.d_mem_addr < WIN0_LIMIT);
    assign in_win1  = (bus.d_mem_addr >= WIN1_BASE) && (bus.d_mem_addr < WIN1_LIMIT);
    assign push_req = run && (bus.d_mem_wen == '1) && (in_win0 || in_win1);

    assign valid   = (cnt_q != '0);
    assign full    = (cnt_q == (FW+1)'(FIFO_DEPTH));
    assign pop     = valid && bus.cap_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push_ok = push_req && (!full || pop);
    assign drop    = push_req && full && !pop;

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!run) begin
                mem_q[clr_ptr_q] <= '0;
            end else if (wr_ok) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    if (bus.d_mem_wen[i]) begin
                        mem_q[word_idx][8*i +: 8] <= bus.d_mem_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        bus.d_mem_rdata = '0;
        if (run && in_range) begin
            bus.d_mem_rdata = mem_q[word_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_win_q[wptr_q]  <= in_win1;
            fifo_addr_q[wptr_q] <= bus.d_mem_addr;
            fifo_data_q[wptr_q] <= bus.d_mem_wdata;
        end
    end

    always_comb begin
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        cnt_d        = cnt_q;
        wr_count_d   = wr_count_q;
        drop_count_d = drop_count_q;
        overflow_d   = overflow_q;
        addr_err_d   = addr_err_q;
        if (push_ok) wptr_d = wptr_q + FW'(1);
        if (pop)     rptr_d = rptr_q + FW'(1);
        if (push_ok && !pop)      cnt_d = cnt_q + (FW+1)'(1);
        else if (!push_ok && pop) cnt_d = cnt_q - (FW+1)'(1);
        if (wr_ok)  wr_count_d = wr_count_q + 32'd1;
        if (wr_bad) addr_err_d = 1'b1;
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_count_q != '1) drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            cnt_q        <= '0;
            wr_count_q   <= '0;
            drop_count_q <= '0;
            overflow_q   <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            cnt_q        <= cnt_d;
            wr_count_q   <= wr_count_d;
            drop_count_q <= drop_count_d;
            overflow_q   <= overflow_d;
            addr_err_q   <= addr_err_d;
        end
    end

    assign bus.init_done    = run;
    assign bus.cap_valid    = valid;
    assign bus.cap_win      = valid ? fifo_win_q[rptr_q]  : 1'b0;
    assign bus.cap_addr     = valid ? fifo_addr_q[rptr_q] : '0;
    assign bus.cap_data     = valid ? fifo_data_q[rptr_q] : '0;
    assign bus.cap_overflow = overflow_q;
    assign bus.drop_count   = drop_count_q;
    assign bus.wr_count     = wr_count_q;
    assign bus.addr_err     = addr_err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a transaction-level model of the
// RAM, clear delay, capture queue and counters, plus literal spot checks.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_responder_if bus();

    dmem_responder #(
        .MEM_SIZE_WORDS(1024),
        .FIFO_DEPTH(16),
        .WIN0_BASE(32'h400),
        .WIN0_LIMIT(32'h430),
        .WIN1_BASE(32'h500),
        .WIN1_LIMIT(32'h530)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic        win;
        logic [31:0] addr;
        logic [31:0] data;
    } cap_t;

    int          errors = 0;
    int          checks = 0;
    bit          mvalid = 0;
    int          clear_left;
    logic [31:0] mmem [1024];
    cap_t        mq [$];
    logic [31:0] m_wr_count;
    logic [15:0] m_drop;
    logic        m_ovf;
    logic        m_aerr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output with the model's view of the current cycle.
    task automatic compare_all();
        logic        e_init;
        logic [31:0] e_rd;
        logic [31:0] a;
        if (!mvalid) return;
        a      = bus.d_mem_addr;
        e_init = (clear_left == 0);
        e_rd   = (e_init && a < 32'd4096) ? mmem[a[11:2]] : 32'd0;
        chk("init_done", bus.init_done, e_init);
        chk("rdata", bus.d_mem_rdata, e_rd);
        chk("cap_valid", bus.cap_valid, mq.size() > 0);
        chk("cap_win", bus.cap_win, mq.size() > 0 ? mq[0].win : 1'b0);
        chk("cap_addr", bus.cap_addr, mq.size() > 0 ? mq[0].addr : 32'd0);
        chk("cap_data", bus.cap_data, mq.size() > 0 ? mq[0].data : 32'd0);
        chk("cap_overflow", bus.cap_overflow, m_ovf);
        chk("drop_count", bus.drop_count, m_drop);
        chk("wr_count", bus.wr_count, m_wr_count);
        chk("addr_err", bus.addr_err, m_aerr);
    endtask

    task automatic model_edge();
        logic [31:0] a, d;
        logic [3:0]  w;
        bit          pop, win_hit;
        cap_t        e;
        a = bus.d_mem_addr;
        d = bus.d_mem_wdata;
        w = bus.d_mem_wen;
        if (rst) begin
            mvalid     = 1;
            clear_left = 1024;
            foreach (mmem[i]) mmem[i] = 32'd0;
            mq.delete();
            m_wr_count = 0;
            m_drop     = 0;
            m_ovf      = 0;
            m_aerr     = 0;
            return;
        end
        if (!mvalid) return;
        pop = (mq.size() > 0) && bus.cap_ready;
        if (pop) void'(mq.pop_front());
        if (clear_left > 0) begin
            clear_left--;
            return;
        end
        if (w != 0) begin
            if (a < 32'd4096) begin
                for (int i = 0; i < 4; i++)
                    if (w[i]) mmem[a[11:2]][8*i +: 8] = d[8*i +: 8];
                m_wr_count++;
            end else begin
                m_aerr = 1;
            end
        end
        win_hit = (a >= 32'h400 && a < 32'h430) || (a >= 32'h500 && a < 32'h530);
        if (w == 4'hF && win_hit) begin
            if (mq.size() < 16) begin
                e.win  = (a >= 32'h500);
                e.addr = a;
                e.data = d;
                mq.push_back(e);
            end else begin
                m_ovf = 1;
                if (m_drop != 16'hFFFF) m_drop++;
            end
        end
    endtask

    // One clock: drive, check mid-cycle, advance the model, land just after the edge.
    task automatic step(input logic r, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] w, input logic rdy);
        rst             = r;
        bus.d_mem_addr  = a;
        bus.d_mem_wdata = d;
        bus.d_mem_wen   = w;
        bus.cap_ready   = rdy;
        @(negedge clk);
        compare_all();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [31:0] a, input logic rdy);
        step(1'b0, a, 32'd0, 4'h0, rdy);
    endtask

    task automatic wait_init(input string name);
        int n = 0;
        while (!bus.init_done && n < 2000) begin
            idle(32'h10, 1'b0);
            n++;
        end
        chk(name, n, 1024);
    endtask

    logic [31:0] ra;
    logic [3:0]  rw;

    initial begin
        rst = 1'b1;
        bus.d_mem_addr = 0; bus.d_mem_wdata = 0; bus.d_mem_wen = 0; bus.cap_ready = 0;
        @(posedge clk); #1;

        repeat (5) step(1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF, 1'b1);
        chk("rst_init_done", bus.init_done, 0);
        chk("rst_cap_valid", bus.cap_valid, 0);
        chk("rst_cap_addr", bus.cap_addr, 0);
        chk("rst_wr_count", bus.wr_count, 0);
        chk("rst_rdata", bus.d_mem_rdata, 0);
        wait_init("clear_latency");
        chk("read_0x10", bus.d_mem_rdata, 0);

        step(1'b0, 32'h20, 32'h11223344, 4'b1111, 1'b0);
        step(1'b0, 32'h20, 32'hAABBCCDD, 4'b0010, 1'b0);
        idle(32'h20, 1'b0);
        chk("lane_read", bus.d_mem_rdata, 32'h1122CC44);
        chk("lane_wr_count", bus.wr_count, 2);

        step(1'b0, 32'h404, 32'd5, 4'hF, 1'b0);
        step(1'b0, 32'h510, 32'hFFFF_FFFE, 4'hF, 1'b0);
        step(1'b0, 32'h408, 32'h1234_5678, 4'b0011, 1'b0);
        idle(32'h0, 1'b0);
        chk("head0_win", bus.cap_win, 0);
        chk("head0_addr", bus.cap_addr, 32'h404);
        chk("head0_data", bus.cap_data, 32'd5);
        idle(32'h0, 1'b1);
        chk("head1_win", bus.cap_win, 1);
        chk("head1_addr", bus.cap_addr, 32'h510);
        chk("head1_data", bus.cap_data, 32'hFFFF_FFFE);
        idle(32'h0, 1'b1);
        chk("drained_valid", bus.cap_valid, 0);

        for (int i = 0; i < 17; i++) step(1'b0, 32'h400, 32'(i), 4'hF, 1'b0);
        idle(32'h0, 1'b0);
        chk("ovf_flag", bus.cap_overflow, 1);
        chk("ovf_drop", bus.drop_count, 1);
        chk("ovf_head", bus.cap_data, 0);
        step(1'b0, 32'h400, 32'hCAFE, 4'hF, 1'b1);
        chk("full_pushpop_drop", bus.drop_count, 1);
        for (int i = 0; i < 40 && bus.cap_valid; i++) idle(32'h0, 1'b1);
        chk("ovf_drained", bus.cap_valid, 0);

        step(1'b0, 32'h1000, 32'h5555_AAAA, 4'hF, 1'b0);
        idle(32'h1000, 1'b0);
        chk("oor_addr_err", bus.addr_err, 1);
        chk("oor_wr_count", bus.wr_count, 23);
        chk("oor_read", bus.d_mem_rdata, 0);

        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: ra = {20'd0, 10'($urandom_range(0, 1023)), 2'($urandom)};
                4, 5, 6:    ra = ($urandom_range(0, 1) ? 32'h400 : 32'h500) - 32'd8
                                 + 32'($urandom_range(0, 32'h40));
                7:          ra = 32'h1000 + 32'($urandom_range(0, 32'hFFFF));
                default:    ra = 32'($urandom_range(0, 32'h40));
            endcase
            rw = ($urandom_range(0, 2) != 0) ? 4'hF : 4'($urandom);
            step(($urandom_range(0, 999) == 0), ra, $urandom, rw, ($urandom_range(0, 3) == 0));
        end
        step(1'b1, 32'h0, 32'h0, 4'h0, 1'b0);
        wait_init("rand_reinit");

        step(1'b0, 32'h30, 32'hDEADBEEF, 4'hF, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h504 + 32'(4*i), 32'(i), 4'hF, 1'b0);
        step(1'b0, 32'h2000, 32'h1, 4'hF, 1'b0);
        idle(32'h30, 1'b0);
        chk("pre_rst_read", bus.d_mem_rdata, 32'hDEADBEEF);
        step(1'b1, 32'h30, 32'h0, 4'h0, 1'b0);
        chk("run_rst_valid", bus.cap_valid, 0);
        chk("run_rst_aerr", bus.addr_err, 0);
        chk("run_rst_wr_count", bus.wr_count, 0);
        repeat (500) idle(32'h30, 1'b0);
        step(1'b1, 32'h30, 32'h0, 4'h0, 1'b0);
        wait_init("midclear_reinit");
        chk("post_rst_read", bus.d_mem_rdata, 0);
        idle(32'h30, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #10ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
